// File: rtl/int_mul_wb_pkg.sv
// Shared types and constants for the integer multiply writeback stage.
//   int_mul_lane_t : ex1 multiply-lane metadata from issue
//   mul_wb_entry_t : one finished result waiting for the CDB
package int_mul_wb_pkg;

  localparam int DATA_LEN     = 32;
  localparam int ROB_TAG_LEN  = 6;
  localparam int PRF_ADDR_LEN = 7;

  // source operand indices into int_mul_lane_t.src
  localparam int RS_1 = 0;
  localparam int RS_2 = 1;

  // RV32M decode (OP opcode, funct7 = 0000001)
  localparam logic [2:0] MUL_FUNC3    = 3'b000;
  localparam logic [2:0] MULH_FUNC3   = 3'b001;
  localparam logic [2:0] MULHSU_FUNC3 = 3'b010;
  localparam logic [2:0] MULHU_FUNC3  = 3'b011;

  typedef struct packed {
    logic                          valid;
    logic [2:0]                    func3;
    logic [1:0][DATA_LEN-1:0]      src;
    logic [ROB_TAG_LEN-1:0]        rob_tag;
    logic [PRF_ADDR_LEN-1:0]       pdst;
  } int_mul_lane_t;

  typedef struct packed {
    logic [DATA_LEN-1:0]     data;
    logic [ROB_TAG_LEN-1:0]  rob_tag;
    logic [PRF_ADDR_LEN-1:0] pdst;
  } mul_wb_entry_t;

endpackage

// File: rtl/mul_rslt_fifo.sv
// Result FIFO for the multiply writeback stage.
//   clk/rst : clock, async active-high reset (storage resets to 0)
//   clr     : synchronous clear, beats push/pop
//   push/wdata, pop/rdata : write and head-of-queue read (no bypass)
//   full/empty/count      : occupancy from extra-MSB pointers
module mul_rslt_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = int_mul_wb_pkg::mul_wb_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // same slot, different lap
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/int_mul_wb.sv
// Integer multiply writeback: ex2 result select / sign correction,
// result FIFO, CDB req/gnt and issue back-pressure.
//   int_mul_lane_info_ex1 / mul_ready_ex1 : ex1 issue and credit
//   mul_prod_ex2 : unsigned 2N-bit product, one cycle after ex1
//   flush        : drop everything in flight and buffered
//   cdb_*        : head-of-FIFO result, held while req && !gnt
module int_mul_wb #(
  parameter int DATA_LEN     = int_mul_wb_pkg::DATA_LEN,
  parameter int DEPTH        = 4,
  parameter int ROB_TAG_LEN  = int_mul_wb_pkg::ROB_TAG_LEN,
  parameter int PRF_ADDR_LEN = int_mul_wb_pkg::PRF_ADDR_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  int_mul_wb_pkg::int_mul_lane_t int_mul_lane_info_ex1,
  output logic                          mul_ready_ex1,
  input  logic [2*DATA_LEN-1:0]         mul_prod_ex2,
  input  logic                          flush,
  output logic                          cdb_req,
  input  logic                          cdb_gnt,
  output logic [DATA_LEN-1:0]           cdb_data,
  output logic [ROB_TAG_LEN-1:0]        cdb_rob_tag,
  output logic [PRF_ADDR_LEN-1:0]       cdb_pdst
);
  import int_mul_wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                    ex2_vld;
  logic [2:0]              ex2_func3;
  logic                    ex2_a_s, ex2_b_s;
  logic [DATA_LEN-1:0]     ex2_src1, ex2_src2;
  logic [ROB_TAG_LEN-1:0]  ex2_rob_tag;
  logic [PRF_ADDR_LEN-1:0] ex2_pdst;

  logic [CW-1:0]           fifo_count;
  logic                    fifo_full, fifo_empty;
  logic [CW:0]             credit_used;
  logic                    accept;
  mul_wb_entry_t           wr_entry, head;

  logic [DATA_LEN-1:0]     hi, lo, corr_a, corr_b, rslt;

  // A pop in the same cycle is not credited back: keeps ready off the gnt path.
  assign credit_used   = {1'b0, fifo_count} + {{CW{1'b0}}, ex2_vld};
  assign mul_ready_ex1 = (credit_used < (CW+1)'(DEPTH));
  assign accept        = mul_ready_ex1 && int_mul_lane_info_ex1.valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex2_vld     <= 1'b0;
      ex2_func3   <= '0;
      ex2_a_s     <= 1'b0;
      ex2_b_s     <= 1'b0;
      ex2_src1    <= '0;
      ex2_src2    <= '0;
      ex2_rob_tag <= '0;
      ex2_pdst    <= '0;
    end else if (flush) begin
      ex2_vld     <= 1'b0;
    end else begin
      ex2_vld <= accept;
      if (accept) begin
        ex2_func3   <= int_mul_lane_info_ex1.func3;
        ex2_a_s     <= int_mul_lane_info_ex1.src[RS_1][DATA_LEN-1];
        ex2_b_s     <= int_mul_lane_info_ex1.src[RS_2][DATA_LEN-1];
        ex2_src1    <= int_mul_lane_info_ex1.src[RS_1];
        ex2_src2    <= int_mul_lane_info_ex1.src[RS_2];
        ex2_rob_tag <= int_mul_lane_info_ex1.rob_tag;
        ex2_pdst    <= int_mul_lane_info_ex1.pdst;
      end
    end
  end

  // Signed high words from the unsigned product: a negative operand's
  // two's-complement reading adds 2^N * other_operand, which is removed here.
  always_comb begin
    hi     = mul_prod_ex2[2*DATA_LEN-1:DATA_LEN];
    lo     = mul_prod_ex2[DATA_LEN-1:0];
    corr_a = ex2_a_s ? ex2_src2 : '0;
    corr_b = ex2_b_s ? ex2_src1 : '0;
    rslt   = lo;
    case (ex2_func3)
      MUL_FUNC3:    rslt = lo;
      MULH_FUNC3:   rslt = hi - corr_a - corr_b;
      MULHSU_FUNC3: rslt = hi - corr_a;
      MULHU_FUNC3:  rslt = hi;
      default:      rslt = lo;
    endcase
  end

  assign wr_entry = '{data: rslt, rob_tag: ex2_rob_tag, pdst: ex2_pdst};

  mul_rslt_fifo #(.DEPTH(DEPTH), .entry_t(mul_wb_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (ex2_vld),
    .wdata (wr_entry),
    .pop   (cdb_req && cdb_gnt),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cdb_req     = !fifo_empty;
  assign cdb_data    = head.data;
  assign cdb_rob_tag = head.rob_tag;
  assign cdb_pdst    = head.pdst;

endmodule

// File: tb/tb_int_mul_wb.sv
module tb_int_mul_wb;
  import int_mul_wb_pkg::*;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int_mul_lane_t lane;
  logic          mul_ready_ex1;
  logic [63:0]   mul_prod_ex2;
  logic          flush, cdb_req, cdb_gnt;
  logic [31:0]   cdb_data;
  logic [5:0]    cdb_rob_tag;
  logic [6:0]    cdb_pdst;

  always #5 clk = ~clk;

  int_mul_wb #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .int_mul_lane_info_ex1 (lane),
    .mul_ready_ex1         (mul_ready_ex1),
    .mul_prod_ex2          (mul_prod_ex2),
    .flush                 (flush),
    .cdb_req               (cdb_req),
    .cdb_gnt               (cdb_gnt),
    .cdb_data              (cdb_data),
    .cdb_rob_tag           (cdb_rob_tag),
    .cdb_pdst              (cdb_pdst)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference: queue of results visible on the CDB plus the one in ex2
  mul_wb_entry_t mq[$];
  logic          m_ex2_v;
  mul_wb_entry_t m_ex2;
  logic          last_req, last_ready;
  logic [31:0]   last_data;
  logic [5:0]    last_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RV32M semantics via sign-extended 64-bit multiplication
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'b001:  begin p = sa * sb; return p[63:32]; end
      3'b010:  begin p = sa * ub; return p[63:32]; end
      3'b011:  begin p = ua * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[31:0];  end
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_outputs();
    logic exp_ready;
    exp_ready = (mq.size() + int'(m_ex2_v)) < DEPTH;
    chk("ready", mul_ready_ex1, exp_ready);
    chk("req", cdb_req, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("data", cdb_data, mq[0].data);
      chk("tag", cdb_rob_tag, mq[0].rob_tag);
      chk("pdst", cdb_pdst, mq[0].pdst);
    end
    chk("no_ovf", dut.ex2_vld & dut.u_fifo.full, 1'b0);
    last_req   = cdb_req;
    last_ready = mul_ready_ex1;
    last_data  = cdb_data;
    last_tag   = cdb_rob_tag;
  endtask

  // one clock: entered and left at posedge+1
  task automatic cycle(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tg, input logic [6:0] pd, input logic g, input logic fl);
    logic acc;
    lane.valid      = v;
    lane.func3      = f3;
    lane.src[RS_1]  = a;
    lane.src[RS_2]  = b;
    lane.rob_tag    = tg;
    lane.pdst       = pd;
    cdb_gnt         = g;
    flush           = fl;
    @(negedge clk);
    check_outputs();
    acc = v && ((mq.size() + int'(m_ex2_v)) < DEPTH);
    if (fl) begin
      mq.delete();
      m_ex2_v = 1'b0;
    end else begin
      if (mq.size() != 0 && g) void'(mq.pop_front());
      if (m_ex2_v) mq.push_back(m_ex2);
      m_ex2_v = acc;
      if (acc) m_ex2 = '{data: ref_result(f3, a, b), rob_tag: tg, pdst: pd};
    end
    @(posedge clk);
    #1;
    mul_prod_ex2 = {32'b0, a} * {32'b0, b};
  endtask

  task automatic idle(input logic g);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 6'd0, 7'd0, g, 1'b0);
  endtask

  task automatic directed(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input logic [5:0] tg);
    cycle(1'b1, f3, a, b, tg, 7'h11, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk({tag, "_req"}, last_req, 1'b1);
    chk({tag, "_data"}, last_data, expv);
    chk({tag, "_tag"}, last_tag, tg);
  endtask

  initial begin
    lane         = '0;
    cdb_gnt      = 1'b0;
    flush        = 1'b0;
    mul_prod_ex2 = '0;
    m_ex2_v      = 1'b0;
    m_ex2        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", cdb_req, 1'b0);
    chk("rst_ready", mul_ready_ex1, 1'b1);
    chk("rst_data", cdb_data, 32'h0);
    chk("rst_tag", cdb_rob_tag, 6'h0);
    chk("rst_pdst", cdb_pdst, 7'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // directed result-select cases
    directed("mul",    3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 6'd1);
    directed("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 6'd2);
    directed("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 6'd3);
    directed("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd4);
    directed("f3_oth", 3'b101, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 6'd5);
    idle(1'b1);

    // back-pressure: gnt low, six back-to-back attempts
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 3'($urandom_range(0, 3)), rnd_op(), rnd_op(), 6'(8 + i), 7'(i), 1'b0, 1'b0);
      if (i == 4) chk("bp_ready_low", last_ready, 1'b0);
    end
    idle(1'b1);
    chk("bp_ready_still_low", last_ready, 1'b0);
    chk("bp_head0", last_tag, 6'd8);
    idle(1'b1);
    chk("bp_ready_back", last_ready, 1'b1);
    chk("bp_head1", last_tag, 6'd9);
    repeat (3) idle(1'b1);

    // flush with three buffered and one in ex2; a valid and a gnt in the flush cycle
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 3'b001, rnd_op(), rnd_op(), 6'(20 + i), 7'(i), 1'b0, 1'b0);
    cycle(1'b1, 3'b000, 32'h7, 32'h9, 6'd30, 7'd30, 1'b1, 1'b1);
    idle(1'b1);
    chk("fl_req", last_req, 1'b0);
    chk("fl_ready", last_ready, 1'b1);
    repeat (2) idle(1'b1);

    // async reset with the FIFO half full
    cycle(1'b1, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 6'd40, 7'd40, 1'b0, 1'b0);
    cycle(1'b1, 3'b000, 32'hCAFE_0001, 32'h0000_0003, 6'd41, 7'd41, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_rst_req", last_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", cdb_req, 1'b0);
    chk("arst_ready", mul_ready_ex1, 1'b1);
    chk("arst_data", cdb_data, 32'h0);
    chk("arst_tag", cdb_rob_tag, 6'h0);
    chk("arst_pdst", cdb_pdst, 7'h0);
    mq.delete();
    m_ex2_v = 1'b0;
    lane    = '0;
    cdb_gnt = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 3'b000, 32'h0000_0006, 32'h0000_0007, 6'd42, 7'd42, 1'b0, 1'b0);
    idle(1'b0);
    chk("lat_n1_req", last_req, 1'b0);
    idle(1'b1);
    chk("lat_n2_req", last_req, 1'b1);
    chk("lat_n2_data", last_data, 32'd42);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd_op(), rnd_op(),
            6'($urandom), 7'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    repeat (DEPTH + 2) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
